fp_add_arbiter: RTL and testbench

Round-robin arbiter that shares one fixed-latency, fully pipelined IEEE-754 single-precision adder (the `Add` core) between NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and issues at most one pair per cycle to the adder. It tags each issue with the requester index and steers each sum back to its owner. It sits between the compute clients and the single shared adder instance.

---
 rtl/fp_pkg.sv | 31 +++
 rtl/fp_add_arbiter_if.sv | 31 +++
 rtl/rr_arbiter.sv | 27 ++
 rtl/fp_add_arbiter.sv | 137 +++++++++++++
 tb/tb_fp_add_arbiter.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fp_pkg.sv
// Shared fp32 types and tag definitions for the shared-adder arbiter and its clients.
package fp_pkg;

  localparam int unsigned FP_W  = 32;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;
  localparam int unsigned IDX_W = 3;   // covers up to 8 requesters
  localparam int unsigned CNT_W = 4;

  typedef struct packed {
    logic             sign;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
  } fp32_t;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } add_tag_t;

  // One-hot (or zero) to binary index; zero maps to index 0.
  function automatic logic [IDX_W-1:0] oh2idx(input logic [7:0] oh);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fp_add_arbiter_if.sv
// Client-side handshakes and shared-adder port bundle for fp_add_arbiter.
interface fp_add_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  import fp_pkg::*;

  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FP_W-1:0] req_a;
  logic [NREQ*FP_W-1:0] req_b;
  logic [NREQ-1:0]      rsp_valid;
  logic [FP_W-1:0]      rsp_sum;
  logic                 add_issue;
  logic [FP_W-1:0]      add_a;
  logic [FP_W-1:0]      add_b;
  logic [FP_W-1:0]      add_sum;
  logic                 busy;

  // Arbiter side
  modport slave (
    input  req_valid, req_a, req_b, add_sum,
    output req_ready, rsp_valid, rsp_sum, add_issue, add_a, add_b, busy
  );

  // Clients plus adder side
  modport master (
    output req_valid, req_a, req_b, add_sum,
    input  req_ready, rsp_valid, rsp_sum, add_issue, add_a, add_b, busy
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first eligible index after ptr_i, wrapping.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_c
);

  logic          found;
  logic [PW-1:0] idx;

  always_comb begin
    gnt_c = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      idx = PW'((32'(ptr_i) + k) % N);
      if (!found && elig_i[idx]) begin
        gnt_c[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one fixed-latency pipelined fp32 adder among NREQ requesters with
// round-robin issue, per-requester credit limits and tagged result steering.
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned ADD_LAT = 3,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  fp_add_arbiter_if.slave  bus
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [NREQ-1:0]  elig_c;
  logic [NREQ-1:0]  gnt_c;
  logic [NREQ-1:0]  tail_hit_c;
  logic             xfer_c;
  logic [IDX_W-1:0] gnt_idx_c;
  fp32_t            op_a_c;
  fp32_t            op_b_c;
  add_tag_t         tail_c;
  logic             tag_any_c;

  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             add_issue_q;
  logic [IDX_W-1:0] iss_idx_q;
  fp32_t            add_a_q, add_a_d;
  fp32_t            add_b_q, add_b_d;
  add_tag_t         tag_q [ADD_LAT];
  logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
  fp32_t            rsp_sum_q, rsp_sum_d;
  logic [CNT_W-1:0] cnt_q [NREQ];
  logic [CNT_W-1:0] cnt_d [NREQ];

  // Credit-gated eligibility
  always_comb begin
    elig_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig_c[i] = bus.req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUT));
    end
  end

  rr_arbiter #(
    .N (NREQ)
  ) u_rr (
    .elig_i (elig_c),
    .ptr_i  (rr_ptr_q),
    .gnt_c  (gnt_c)
  );

  assign xfer_c    = |gnt_c;
  assign gnt_idx_c = oh2idx(8'(gnt_c));
  assign tail_c    = tag_q[ADD_LAT-1];

  // Operand mux for the granted requester
  always_comb begin
    op_a_c = '0;
    op_b_c = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_c[i]) begin
        op_a_c = fp32_t'(bus.req_a[FP_W*i +: FP_W]);
        op_b_c = fp32_t'(bus.req_b[FP_W*i +: FP_W]);
      end
    end
  end

  // Next-state: pointer, issue regs, response steering and credits
  always_comb begin
    rr_ptr_d    = rr_ptr_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_valid_d = '0;
    rsp_sum_d   = rsp_sum_q;
    tail_hit_c  = '0;
    tag_any_c   = add_issue_q;

    if (xfer_c) begin
      rr_ptr_d = PW'(gnt_idx_c);
      add_a_d  = op_a_c;
      add_b_d  = op_b_c;
    end

    for (int i = 0; i < NREQ; i++) begin
      tail_hit_c[i] = tail_c.valid && (tail_c.idx == IDX_W'(i));
    end
    rsp_valid_d = tail_hit_c;
    if (tail_c.valid) rsp_sum_d = fp32_t'(bus.add_sum);

    // Decrement lands with the rising response pulse, so a capped requester
    // is eligible again during the cycle its pulse is visible.
    for (int i = 0; i < NREQ; i++) begin
      cnt_d[i] = cnt_q[i] + CNT_W'(gnt_c[i]) - CNT_W'(tail_hit_c[i]);
    end

    for (int k = 0; k < ADD_LAT; k++) begin
      tag_any_c = tag_any_c | tag_q[k].valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= PW'(NREQ - 1);
      add_issue_q <= 1'b0;
      iss_idx_q   <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_sum_q   <= '0;
      for (int k = 0; k < ADD_LAT; k++) tag_q[k] <= '0;
      for (int i = 0; i < NREQ; i++)    cnt_q[i] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      add_issue_q <= xfer_c;
      iss_idx_q   <= gnt_idx_c;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
      // Tag tracks the issue register through the ADD_LAT adder stages
      tag_q[0]    <= add_tag_t'{valid: add_issue_q, idx: iss_idx_q};
      for (int k = 1; k < ADD_LAT; k++) tag_q[k] <= tag_q[k-1];
      for (int i = 0; i < NREQ; i++)    cnt_q[i] <= cnt_d[i];
    end
  end

  assign bus.req_ready = gnt_c;
  assign bus.add_issue = add_issue_q;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.busy      = tag_any_c | (|rsp_valid_q);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter with a behavioural pipelined adder and a
// response scoreboard keyed on observed transfers.
module tb_fp_add_arbiter;
  import fp_pkg::*;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned ADD_LAT = 3;
  localparam int unsigned MAX_OUT = 2;
  localparam int          RSP_DLY = 5;

  typedef struct packed {
    int          cyc;
    int          idx;
    logic [31:0] sum;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t exp_q [$];
  exp_t e;
  logic [31:0] add_pipe [ADD_LAT];

  logic [1:0] cont_rdy [6]  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b01};
  logic       cred_rdy [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [1:0] rmf_rdy  [3]  = '{2'b10, 2'b01, 2'b10};

  always #5 clk = ~clk;

  fp_add_arbiter_if #(.NREQ(NREQ)) bus ();

  fp_add_arbiter #(
    .NREQ    (NREQ),
    .ADD_LAT (ADD_LAT),
    .MAX_OUT (MAX_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h40A0_0000) return 32'h40C0_0000;
    return a + b;
  endfunction

  // Adder model: free-running, not reset, so it keeps emitting across resets
  always @(posedge clk) begin
    add_pipe[0] <= model_add(bus.add_a, bus.add_b);
    for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
    cyc <= cyc + 1;
  end
  assign bus.add_sum = add_pipe[ADD_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted pair must come back once, in order, 5 cycles later
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_onehot0", 32'($onehot0(bus.req_ready)), 32'd1);
      for (int i = 0; i < NREQ; i++) begin
        check("cnt_le_max", 32'(dut.cnt_q[i] > 4'(MAX_OUT)), 32'd0);
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          exp_q.push_back('{cyc: cyc + RSP_DLY, idx: i,
                            sum: model_add(bus.req_a[32*i +: 32], bus.req_b[32*i +: 32])});
        end
      end
      if (bus.rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rsp_cycle", cyc, e.cyc);
          check("rsp_owner", 32'(bus.rsp_valid), 32'd1 << e.idx);
          check("rsp_sum", bus.rsp_sum, e.sum);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_issue", 32'(bus.add_issue), 32'd0);
    check("rst_add_a", bus.add_a, 32'd0);
    check("rst_add_b", bus.add_b, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_sum", bus.rsp_sum, 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;
    step();
    step();

    // Contention: both valid for 6 cycles, credits cap at 2 each
    for (int k = 0; k < 6; k++) begin
      bus.req_valid = 2'b11;
      bus.req_a     = {32'h2000 + 32'(k), 32'h1000 + 32'(k)};
      bus.req_b     = {32'd2, 32'd1};
      #2;
      check("cont_ready", 32'(bus.req_ready), 32'(cont_rdy[k]));
      step();
    end
    bus.req_valid = '0;
    repeat (8) step();
    check("cont_busy_done", 32'(bus.busy), 32'd0);
    check("cont_cnt0", 32'(dut.cnt_q[0]), 32'd0);
    check("cont_cnt1", 32'(dut.cnt_q[1]), 32'd0);

    // Single request 1.0 + 5.0 from requester 0
    bus.req_valid = 2'b01;
    bus.req_a     = {32'd0, 32'h3F80_0000};
    bus.req_b     = {32'd0, 32'h40A0_0000};
    #2;
    check("single_ready", 32'(bus.req_ready), 32'b01);
    step();
    bus.req_valid = '0;
    check("single_issue", 32'(bus.add_issue), 32'd1);
    check("single_add_a", bus.add_a, 32'h3F80_0000);
    check("single_add_b", bus.add_b, 32'h40A0_0000);
    check("single_busy", 32'(bus.busy), 32'd1);
    check("single_cnt", 32'(dut.cnt_q[0]), 32'd1);
    for (int d = 1; d <= 3; d++) begin
      step();
      if (d == 1) check("single_issue_drop", 32'(bus.add_issue), 32'd0);
      check("single_rsp_early", 32'(bus.rsp_valid), 32'd0);
    end
    step();
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'b01);
    check("single_rsp_sum", bus.rsp_sum, 32'h40C0_0000);
    check("single_busy_rsp", 32'(bus.busy), 32'd1);
    step();
    check("single_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    check("single_busy_after", 32'(bus.busy), 32'd0);
    check("single_cnt_after", 32'(dut.cnt_q[0]), 32'd0);

    // Credit limit on requester 1
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = 2'b10;
      bus.req_a     = {32'h3000 + 32'(k), 32'd0};
      bus.req_b     = {32'd1, 32'd0};
      #2;
      check("credit_ready", 32'(bus.req_ready), {31'd0, cred_rdy[k]} << 1);
      step();
    end
    bus.req_valid = '0;
    repeat (8) step();
    check("credit_cnt_done", 32'(dut.cnt_q[1]), 32'd0);

    // Transfer for req0 on the same edge its earlier response rises
    for (int k = 0; k < 5; k++) begin
      bus.req_valid = (k == 0 || k == 4) ? 2'b01 : 2'b00;
      bus.req_a     = {32'd0, 32'h4000 + 32'(k)};
      bus.req_b     = {32'd0, 32'd7};
      #2;
      check("simul_ready", 32'(bus.req_ready), 32'(bus.req_valid));
      step();
      if (k == 0) check("simul_cnt_first", 32'(dut.cnt_q[0]), 32'd1);
    end
    bus.req_valid = '0;
    check("simul_rsp", 32'(bus.rsp_valid), 32'b01);
    check("simul_issue", 32'(bus.add_issue), 32'd1);
    check("simul_cnt_hold", 32'(dut.cnt_q[0]), 32'd1);
    repeat (4) step();
    check("simul_rsp2", 32'(bus.rsp_valid), 32'b01);
    check("simul_cnt_zero", 32'(dut.cnt_q[0]), 32'd0);
    step();
    check("simul_busy_done", 32'(bus.busy), 32'd0);

    // Reset with three operations in flight
    for (int k = 0; k < 3; k++) begin
      bus.req_valid = 2'b11;
      bus.req_a     = {32'h6000 + 32'(k), 32'h5000 + 32'(k)};
      bus.req_b     = {32'd3, 32'd3};
      #2;
      check("rmf_ready", 32'(bus.req_ready), 32'(rmf_rdy[k]));
      step();
    end
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("rmf_ready_rst", 32'(bus.req_ready), 32'd0);
    check("rmf_issue_rst", 32'(bus.add_issue), 32'd0);
    check("rmf_add_a_rst", bus.add_a, 32'd0);
    check("rmf_add_b_rst", bus.add_b, 32'd0);
    check("rmf_rsp_valid_rst", 32'(bus.rsp_valid), 32'd0);
    check("rmf_rsp_sum_rst", bus.rsp_sum, 32'd0);
    check("rmf_busy_rst", 32'(bus.busy), 32'd0);
    check("rmf_cnt0_rst", 32'(dut.cnt_q[0]), 32'd0);
    check("rmf_cnt1_rst", 32'(dut.cnt_q[1]), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      check("rmf_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    // Pointer restarts at NREQ-1, so requester 0 wins first
    bus.req_valid = 2'b11;
    bus.req_a     = {32'h7001, 32'h7000};
    bus.req_b     = {32'd1, 32'd1};
    #2;
    check("rmf_first_grant", 32'(bus.req_ready), 32'b01);
    step();
    bus.req_valid = '0;
    repeat (8) step();

    // Idle
    for (int k = 0; k < 20; k++) begin
      step();
      check("idle_issue", 32'(bus.add_issue), 32'd0);
      check("idle_rsp", 32'(bus.rsp_valid), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
    end

    check("exp_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
